// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU op codes, bus source codes, sequencer state encoding
// and op decode helpers shared by the alu_seq_ctrl slice.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h3;
    localparam logic [3:0] ALU_SHR = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h5;
    localparam logic [3:0] ALU_ROR = 4'h6;
    localparam logic [3:0] ALU_ROL = 4'h7;
    localparam logic [3:0] ALU_MUL = 4'h8;
    localparam logic [3:0] ALU_DIV = 4'h9;
    localparam logic [3:0] ALU_NEG = 4'hA;
    localparam logic [3:0] ALU_NOT = 4'hB;

    localparam logic [4:0] BUS_SRC_ZLO  = 5'd16;
    localparam logic [4:0] BUS_SRC_ZHI  = 5'd17;
    localparam logic [4:0] BUS_SRC_NONE = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_Y,
        ST_EXEC,
        ST_WAIT,
        ST_WB_LO,
        ST_WB_HI,
        ST_ILLEGAL,
        ST_DZ_ABORT
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > ALU_NOT;
    endfunction

endpackage

// File: rtl/alu_seq_wait_cnt.sv
// alu_seq_wait_cnt: 4-bit loadable down counter with zero flag,
// times the mul/div settle window of alu_seq_ctrl.
module alu_seq_wait_cnt (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the single-bus ALU datapath.
// Optional macro ALU_SEQ_DIVZERO_CHK_EN adds divide-by-zero abort.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int REG_SIZE      = 32,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic [3:0] rs_sel,
    input  logic [3:0] rt_sel,
    input  logic [3:0] rd_sel,
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    input  logic       bus_zero,
    output logic       div_zero,
`endif
    output logic [4:0] bus_src_sel,
    output logic       y_in,
    output logic       z_in,
    output logic [3:0] alu_ctrl,
    output logic       gpr_in,
    output logic [3:0] gpr_in_sel,
    output logic       lo_in,
    output logic       hi_in,
    output logic       done,
    output logic       illegal_op
);

    if ((MULDIV_CYCLES < 1) || (MULDIV_CYCLES > 15) || (REG_SIZE < 1)) begin : g_param_chk
        $error("alu_seq_ctrl: MULDIV_CYCLES must be 1..15");
    end

    localparam logic [3:0] LP_WAIT_INIT = 4'(MULDIV_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_op;
    logic [3:0] r_rs;
    logic [3:0] r_rt;
    logic [3:0] r_rd;
    logic       w_accept;
    logic       w_md;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_zero;

    assign w_accept   = op_valid && (r_state == ST_IDLE);
    assign w_md       = is_muldiv(r_op);
    assign w_cnt_load = (r_state == ST_EXEC) && w_md;
    assign w_cnt_dec  = (r_state == ST_WAIT);

    alu_seq_wait_cnt u_wait_cnt (
        .clock      (clock),
        .clear_n    (clear_n),
        .i_load     (w_cnt_load),
        .i_load_val (LP_WAIT_INIT),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_op <= '0;
            r_rs <= '0;
            r_rt <= '0;
            r_rd <= '0;
        end else if (w_accept) begin
            r_op <= op_code;
            r_rs <= rs_sel;
            r_rt <= rt_sel;
            r_rd <= rd_sel;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    w_next = is_illegal(op_code) ? ST_ILLEGAL : ST_LOAD_Y;
                end
            end
            ST_ILLEGAL:  w_next = ST_IDLE;
            ST_LOAD_Y:   w_next = ST_EXEC;
            ST_EXEC: begin
                if (!w_md) begin
                    w_next = ST_WB_LO;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
                end else if ((r_op == ALU_DIV) && bus_zero) begin
                    w_next = ST_DZ_ABORT;
`endif
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_next = ST_WB_LO;
                end
            end
            ST_WB_LO:    w_next = w_md ? ST_WB_HI : ST_IDLE;
            ST_WB_HI:    w_next = ST_IDLE;
            ST_DZ_ABORT: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Moore outputs: only registered state and latched fields feed these
    always_comb begin
        op_ready    = 1'b0;
        bus_src_sel = BUS_SRC_NONE;
        y_in        = 1'b0;
        z_in        = 1'b0;
        alu_ctrl    = ALU_AND;
        gpr_in      = 1'b0;
        gpr_in_sel  = 4'd0;
        lo_in       = 1'b0;
        hi_in       = 1'b0;
        done        = 1'b0;
        illegal_op  = 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        div_zero    = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: op_ready = 1'b1;
            ST_ILLEGAL: begin
                done       = 1'b1;
                illegal_op = 1'b1;
            end
            ST_LOAD_Y: begin
                bus_src_sel = {1'b0, r_rs};
                y_in        = 1'b1;
            end
            ST_EXEC: begin
                bus_src_sel = {1'b0, r_rt};
                alu_ctrl    = r_op;
                z_in        = !w_md;
            end
            ST_WAIT: begin
                bus_src_sel = {1'b0, r_rt};
                alu_ctrl    = r_op;
                z_in        = w_cnt_zero;
            end
            ST_WB_LO: begin
                bus_src_sel = BUS_SRC_ZLO;
                if (w_md) begin
                    lo_in = 1'b1;
                end else begin
                    gpr_in     = 1'b1;
                    gpr_in_sel = r_rd;
                    done       = 1'b1;
                end
            end
            ST_WB_HI: begin
                bus_src_sel = BUS_SRC_ZHI;
                hi_in       = 1'b1;
                done        = 1'b1;
            end
            ST_DZ_ABORT: begin
                done = 1'b1;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
                div_zero = 1'b1;
`endif
            end
            default: op_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table, directed and random checks of alu_seq_ctrl
// against a per-operation expected-trace model.
module tb_alu_seq_ctrl;

    localparam int MDC = 4;

    typedef struct packed {
        logic       ready;
        logic [4:0] bus;
        logic       y;
        logic       z;
        logic [3:0] alu;
        logic       gpr;
        logic [3:0] gsel;
        logic       lo;
        logic       hi;
        logic       done;
        logic       ill;
        logic       dz;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        int         lat;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [3:0] rs_sel;
    logic [3:0] rt_sel;
    logic [3:0] rd_sel;
    logic [4:0] bus_src_sel;
    logic       y_in;
    logic       z_in;
    logic [3:0] alu_ctrl;
    logic       gpr_in;
    logic [3:0] gpr_in_sel;
    logic       lo_in;
    logic       hi_in;
    logic       done;
    logic       illegal_op;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    logic       bus_zero;
    logic       div_zero;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    out_t exp_q[$];

    always #5 clock = ~clock;

    alu_seq_ctrl #(
        .REG_SIZE      (32),
        .MULDIV_CYCLES (MDC)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .rs_sel      (rs_sel),
        .rt_sel      (rt_sel),
        .rd_sel      (rd_sel),
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        .bus_zero    (bus_zero),
        .div_zero    (div_zero),
`endif
        .bus_src_sel (bus_src_sel),
        .y_in        (y_in),
        .z_in        (z_in),
        .alu_ctrl    (alu_ctrl),
        .gpr_in      (gpr_in),
        .gpr_in_sel  (gpr_in_sel),
        .lo_in       (lo_in),
        .hi_in       (hi_in),
        .done        (done),
        .illegal_op  (illegal_op)
    );

    function automatic out_t blank(input logic [4:0] bus);
        out_t o;
        o = '0;
        o.bus = bus;
        return o;
    endfunction

    function automatic out_t idle_out();
        out_t o;
        o = blank(5'd31);
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.ready = op_ready;
        o.bus   = bus_src_sel;
        o.y     = y_in;
        o.z     = z_in;
        o.alu   = alu_ctrl;
        o.gpr   = gpr_in;
        o.gsel  = gpr_in_sel;
        o.lo    = lo_in;
        o.hi    = hi_in;
        o.done  = done;
        o.ill   = illegal_op;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        o.dz    = div_zero;
`else
        o.dz    = 1'b0;
`endif
        return o;
    endfunction

    // Expected per-cycle outputs after an accept, straight from the op rules
    function automatic void build_exp(input logic [3:0] op, input logic [3:0] rs,
                                      input logic [3:0] rt, input logic [3:0] rd);
        out_t o;
        bit   md;
        exp_q.delete();
        if (op >= 4'hC) begin
            o = blank(5'd31);
            o.done = 1'b1;
            o.ill  = 1'b1;
            exp_q.push_back(o);
            return;
        end
        md = (op == 4'h8) || (op == 4'h9);
        o = blank({1'b0, rs});
        o.y = 1'b1;
        exp_q.push_back(o);
        if (!md) begin
            o = blank({1'b0, rt});
            o.alu = op;
            o.z   = 1'b1;
            exp_q.push_back(o);
            o = blank(5'd16);
            o.gpr  = 1'b1;
            o.gsel = rd;
            o.done = 1'b1;
            exp_q.push_back(o);
        end else begin
            for (int i = 0; i < MDC + 1; i++) begin
                o = blank({1'b0, rt});
                o.alu = op;
                o.z   = (i == MDC);
                exp_q.push_back(o);
            end
            o = blank(5'd16);
            o.lo = 1'b1;
            exp_q.push_back(o);
            o = blank(5'd17);
            o.hi   = 1'b1;
            o.done = 1'b1;
            exp_q.push_back(o);
        end
    endfunction

    task automatic check(input string nm, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle
    task automatic run_op(input string nm, input logic [3:0] op, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [3:0] rd,
                          input bit noise, output int lat);
        out_t got;
        int   n;
        build_exp(op, rs, rt, rd);
        n = exp_q.size();
        op_code  = op;
        rs_sel   = rs;
        rt_sel   = rt;
        rd_sel   = rd;
        op_valid = 1'b1;
        @(posedge clock);
        #1;
        op_valid = noise;
        op_code  = 4'($urandom);
        rs_sel   = 4'($urandom);
        rt_sel   = 4'($urandom);
        rd_sel   = 4'($urandom);
        lat = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            got = sample();
            check($sformatf("%s c%0d", nm, k), got, exp_q[k]);
            if (got.done && lat == 0) lat = k + 1;
            if (k == n - 1) op_valid = 1'b0;
        end
        @(negedge clock);
        check($sformatf("%s idle", nm), sample(), idle_out());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        out_t o;
        int   lat;
        int   dones;
        bit   want_done;

        tbl[0] = '{op: 4'h2, rs: 4'd3,  rt: 4'd4,  rd: 4'd5,  lat: 3};
        tbl[1] = '{op: 4'h8, rs: 4'd1,  rt: 4'd2,  rd: 4'd6,  lat: 8};
        tbl[2] = '{op: 4'hE, rs: 4'd7,  rt: 4'd8,  rd: 4'd9,  lat: 1};
        tbl[3] = '{op: 4'h0, rs: 4'd15, rt: 4'd0,  rd: 4'd15, lat: 3};
        tbl[4] = '{op: 4'h9, rs: 4'd7,  rt: 4'd8,  rd: 4'd9,  lat: 8};
        tbl[5] = '{op: 4'hA, rs: 4'd2,  rt: 4'd2,  rd: 4'd1,  lat: 3};
        tbl[6] = '{op: 4'hB, rs: 4'd12, rt: 4'd11, rd: 4'd10, lat: 3};
        tbl[7] = '{op: 4'hF, rs: 4'd1,  rt: 4'd1,  rd: 4'd1,  lat: 1};
        tbl[8] = '{op: 4'h4, rs: 4'd9,  rt: 4'd14, rd: 4'd0,  lat: 3};
        tbl[9] = '{op: 4'hC, rs: 4'd0,  rt: 4'd0,  rd: 4'd0,  lat: 1};

        clear_n  = 1'b0;
        op_valid = 1'b0;
        op_code  = '0;
        rs_sel   = '0;
        rt_sel   = '0;
        rd_sel   = '0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        bus_zero = 1'b0;
`endif
        #3;
        check("reset async", sample(), idle_out());
        @(negedge clock);
        check("reset held", sample(), idle_out());
        clear_n = 1'b1;
        @(negedge clock);
        check("after reset", sample(), idle_out());

        foreach (tbl[i]) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                   tbl[i].rd, 1'b0, lat);
            check_int($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
        end

        // Reset pulse while a div sits in its settle window
        op_code  = 4'h9;
        rs_sel   = 4'd1;
        rt_sel   = 4'd2;
        rd_sel   = 4'd3;
        op_valid = 1'b1;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        repeat (3) @(negedge clock);
        o = blank(5'd2);
        o.alu = 4'h9;
        check("div in wait", sample(), o);
        #2;
        clear_n = 1'b0;
        #1;
        check("mid-op reset", sample(), idle_out());
        @(negedge clock);
        clear_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("post-reset c%0d", i), sample(), idle_out());
        end

        // op_valid held across two back-to-back ands
        op_code  = 4'h0;
        rs_sel   = 4'd1;
        rt_sel   = 4'd2;
        rd_sel   = 4'd3;
        op_valid = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            o = sample();
            want_done = (i == 2) || (i == 6);
            check_int($sformatf("b2b done c%0d", i), int'(o.done), int'(want_done));
            check_int($sformatf("b2b ready c%0d", i), int'(o.ready),
                      int'(i == 3 || i >= 7));
            if (o.done) dones++;
            if (dones == 2) op_valid = 1'b0;
        end
        check_int("b2b done count", dones, 2);

`ifdef ALU_SEQ_DIVZERO_CHK_EN
        bus_zero = 1'b1;
        op_code  = 4'h9;
        rs_sel   = 4'd4;
        rt_sel   = 4'd0;
        rd_sel   = 4'd1;
        op_valid = 1'b1;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        @(negedge clock);
        o = blank(5'd4);
        o.y = 1'b1;
        check("dz load_y", sample(), o);
        @(negedge clock);
        o = blank(5'd0);
        o.alu = 4'h9;
        check("dz exec", sample(), o);
        @(negedge clock);
        o = blank(5'd31);
        o.done = 1'b1;
        o.dz   = 1'b1;
        check("dz abort", sample(), o);
        @(negedge clock);
        check("dz idle", sample(), idle_out());
        bus_zero = 1'b0;
        run_op("dz nonzero", 4'h9, 4'd4, 4'd5, 4'd1, 1'b0, lat);
        check_int("dz nonzero latency", lat, 8);
`endif

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                check($sformatf("rnd%0d gap", i), sample(), idle_out());
            end
            run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                   4'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom_range(0, 1)), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
